cla_pipe_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 19 +
 rtl/cla_group4.sv | 41 ++++
 rtl/cla_pipe_adder.sv | 148 ++++++++++++++
 tb/tb_cla_pipe_adder.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   GROUP_W            : width of one lookahead group (one pipeline stage per group)
//   MODE_ADD/MODE_SUB  : encodings of the 'sub' input
//   stage_t            : per-stage control record; the partial sum lives next to it in a
//                        width-dependent array in the top level
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic valid;  // operation present in this stage
    logic carry;  // carry out of the group computed by this stage
    logic ovf;    // carry into group MSB xor carry out; meaningful for the last stage
  } stage_t;

endpackage

// File: rtl/cla_group4.sv
// Purely combinational 4-bit carry-lookahead group.
// Ports:
//   a, b      : 4-bit operand slices (b already inverted for subtraction)
//   c_in      : carry into bit 0 of the group
//   s         : 4-bit sum slice
//   c_out     : carry out of bit 3
//   c_msb_in  : carry into bit 3 (used for signed overflow)
//   gp, gg    : group propagate / group generate
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out,
  output logic       c_msb_in,
  output logic       gp,
  output logic       gg
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Flat two-level lookahead: every carry is a sum of products of g, p and c_in.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

  assign c_out    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & c_in);
  assign c_msb_in = c[3];
  assign s        = p ^ c;

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor, one 4-bit group per pipeline stage.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : input handshake; one operation per cycle when not stalled
//   a, b, cin, sub       : operands; sub=1 computes a + ~b + 1 and ignores cin
//   out_valid / out_ready: output handshake
//   sum, cout, ovf       : result, carry out of MSB (1 = no borrow on subtract), signed overflow
// Latency is NGROUPS cycles; a stalled output freezes the whole pipeline (no bubble squeeze).
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NGROUPS = WIDTH / GROUP_W;
  localparam int unsigned LAST    = NGROUPS - 1;

  if ((WIDTH % GROUP_W) != 0 || WIDTH < GROUP_W) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a non-zero multiple of 4");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Group interconnect
  logic [GROUP_W-1:0] grp_a [NGROUPS];
  logic [GROUP_W-1:0] grp_b [NGROUPS];
  logic [GROUP_W-1:0] grp_s [NGROUPS];
  logic [NGROUPS-1:0] grp_cin;
  logic [NGROUPS-1:0] grp_cout;
  logic [NGROUPS-1:0] grp_cmsb;
  logic [NGROUPS-1:0] grp_gp;
  logic [NGROUPS-1:0] grp_gg;

  // Stage state: control record, accumulated sum, and operand skew registers. The skew
  // registers are pre-shifted so the next stage always finds its slice in bits [3:0].
  stage_t           stage_q [NGROUPS];
  stage_t           stage_d [NGROUPS];
  logic [WIDTH-1:0] sum_q   [NGROUPS];
  logic [WIDTH-1:0] sum_d   [NGROUPS];
  logic [WIDTH-1:0] a_q     [NGROUPS];
  logic [WIDTH-1:0] a_d     [NGROUPS];
  logic [WIDTH-1:0] b_q     [NGROUPS];
  logic [WIDTH-1:0] b_d     [NGROUPS];

  assign b_eff   = (sub == MODE_SUB) ? ~b : b;
  assign cin_eff = (sub == MODE_ADD) ? cin : 1'b1;

  assign out_valid = stage_q[LAST].valid;
  assign sum       = sum_q[LAST];
  assign cout      = stage_q[LAST].carry;
  assign ovf       = stage_q[LAST].ovf;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
    if (k == 0) begin : g_first
      assign grp_a[k]   = a[GROUP_W-1:0];
      assign grp_b[k]   = b_eff[GROUP_W-1:0];
      assign grp_cin[k] = cin_eff;
    end else begin : g_rest
      assign grp_a[k]   = a_q[k-1][GROUP_W-1:0];
      assign grp_b[k]   = b_q[k-1][GROUP_W-1:0];
      assign grp_cin[k] = stage_q[k-1].carry;
    end

    cla_group4 u_grp (
      .a        (grp_a[k]),
      .b        (grp_b[k]),
      .c_in     (grp_cin[k]),
      .s        (grp_s[k]),
      .c_out    (grp_cout[k]),
      .c_msb_in (grp_cmsb[k]),
      .gp       (grp_gp[k]),
      .gg       (grp_gg[k])
    );
  end

  always_comb begin
    stage_d = stage_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;

    // Stage 0 loads from the ports; when enabled, in_ready is 1 so in_valid means accept.
    stage_d[0].valid = in_valid;
    if (in_valid) begin
      stage_d[0].carry = grp_cout[0];
      stage_d[0].ovf   = grp_cmsb[0] ^ grp_cout[0];
      sum_d[0]         = WIDTH'(grp_s[0]);
      a_d[0]           = a >> GROUP_W;
      b_d[0]           = b_eff >> GROUP_W;
    end

    // Data only moves with a valid operation, so bubbles leave the old values in place.
    for (int unsigned k = 1; k < NGROUPS; k++) begin
      stage_d[k].valid = stage_q[k-1].valid;
      if (stage_q[k-1].valid) begin
        stage_d[k].carry                 = grp_cout[k];
        stage_d[k].ovf                   = grp_cmsb[k] ^ grp_cout[k];
        sum_d[k]                         = sum_q[k-1];
        sum_d[k][k*GROUP_W +: GROUP_W]   = grp_s[k];
        a_d[k]                           = a_q[k-1] >> GROUP_W;
        b_d[k]                           = b_q[k-1] >> GROUP_W;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NGROUPS; k++) begin
        stage_q[k] <= '0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end
    end else if (!stall) begin
      stage_q <= stage_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

`ifndef SYNTHESIS
  // Group carry out must agree with its own generate/propagate terms.
  assert property (@(posedge clk) disable iff (rst)
    grp_cout == (grp_gg | (grp_gp & grp_cin)))
    else $error("cla_pipe_adder: group carry inconsistent with G/P");
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=16, latency 4).
module tb_cla_pipe_adder;

  localparam int W  = 16;
  localparam int NG = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Delay-line model of the pipeline plus an in-order scoreboard of accepted results.
  bit          mdl_v [NG];
  logic [17:0] mdl_r [NG];
  logic [17:0] sb [$];
  bit          last_acc = 1'b0;

  logic [15:0] dir_a  [5] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0003};
  logic [15:0] dir_b  [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0005};
  logic        dir_c  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        dir_s  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [17:0] dir_ex [5] = '{{2'b00, 16'h0100}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                              {2'b11, 16'h7FFF}, {2'b00, 16'hFFFE}};

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: plain arithmetic, overflow from the sign rule. Returns {ovf, cout, sum}.
  function automatic logic [17:0] ref_op(logic [15:0] ra, logic [15:0] rb, logic rc,
                                         logic rs);
    logic [15:0] be;
    logic        ci;
    logic [16:0] full;
    logic        v;
    be   = rs ? ~rb : rb;
    ci   = rs ? 1'b1 : rc;
    full = {1'b0, ra} + {1'b0, be} + {16'd0, ci};
    v    = (ra[15] == be[15]) && (full[15] != ra[15]);
    return {v, full[16], full[15:0]};
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < NG; k++) begin
      mdl_v[k] = 1'b0;
      mdl_r[k] = '0;
    end
    sb.delete();
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    bit st;
    bit acc;
    logic [17:0] r;
    st  = mdl_v[NG-1] && !out_ready;
    acc = in_valid && !st;
    r   = ref_op(a, b, cin, sub);
    if (acc) sb.push_back(r);
    @(posedge clk);
    if (!st) begin
      for (int k = NG - 1; k > 0; k--) begin
        if (mdl_v[k-1]) mdl_r[k] = mdl_r[k-1];
        mdl_v[k] = mdl_v[k-1];
      end
      mdl_v[0] = acc;
      if (acc) mdl_r[0] = r;
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_idle();
    out_ready = 1'b1;
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if ({ovf, cout, sum} !== 18'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {ovf, cout, sum});
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = dir_a[i];
      b = dir_b[i];
      cin = dir_c[i];
      sub = dir_s[i];
      tick();
      drive_idle();
      for (int c = 1; c < NG; c++) begin
        n_checks++;
        if (out_valid !== 1'b0) begin
          n_fail++; $display("FAIL dir_latency[%0d] after %0d edges: out_valid %b want 0",
                             i, c, out_valid);
        end
        tick();
      end
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL dir_valid[%0d]: out_valid %b want 1", i, out_valid);
      end
      n_checks++;
      if ({ovf, cout, sum} !== dir_ex[i]) begin
        n_fail++; $display("FAIL dir_result[%0d]: {ovf,cout,sum} %h want %h",
                           i, {ovf, cout, sum}, dir_ex[i]);
      end
      tick();
    end
    for (int c = 0; c < NG; c++) tick();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int got = 0;
    int cyc = 0;
    sb.delete();
    while (got < 8 && cyc < 40) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (idx < 8) begin
        in_valid = 1'b1;
        a = 16'(idx);
        b = 16'h1000;
        cin = 1'b0;
        sub = 1'b0;
      end else begin
        drive_idle();
      end
      #1;
      n_checks++;
      if (in_ready !== !(mdl_v[NG-1] && !out_ready)) begin
        n_fail++; $display("FAIL bp_in_ready cyc %0d: got %b", cyc, in_ready);
      end
      n_checks++;
      if (out_valid !== mdl_v[NG-1]) begin
        n_fail++; $display("FAIL bp_out_valid cyc %0d: got %b want %b", cyc, out_valid,
                           mdl_v[NG-1]);
      end
      if (cyc >= 5 && cyc <= 7) begin
        n_checks++;
        if (in_ready !== 1'b0 || sum !== 16'h1001) begin
          n_fail++; $display("FAIL bp_stall_hold cyc %0d: in_ready %b sum %h want 0 / 1001",
                             cyc, in_ready, sum);
        end
      end
      if (mdl_v[NG-1] && out_ready) begin
        n_checks++;
        if (sum !== 16'h1000 + 16'(got) || cout !== 1'b0 || ovf !== 1'b0) begin
          n_fail++; $display("FAIL bp_order result %0d: sum %h want %h", got, sum,
                             16'h1000 + 16'(got));
        end
        got++;
      end
      tick();
      if (last_acc) idx++;
      cyc++;
    end
    n_checks++;
    if (got !== 8) begin
      n_fail++; $display("FAIL bp_count: got %0d results want 8", got);
    end
    n_checks++;
    if (cyc !== 15) begin
      n_fail++; $display("FAIL bp_cycles: took %0d cycles want 15", cyc);
    end
    drive_idle();
    out_ready = 1'b1;
    for (int c = 0; c < NG; c++) tick();
  endtask

  task automatic test_reset_mid();
    logic [17:0] exp;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'b0;
      tick();
    end
    drive_idle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_clear();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_valid: got %b want 0", out_valid);
    end
    n_checks++;
    if ({ovf, cout, sum} !== 18'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h want 0", {ovf, cout, sum});
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    a = 16'h1234;
    b = 16'h4321;
    cin = 1'b1;
    sub = 1'b0;
    exp = ref_op(a, b, cin, sub);
    tick();
    drive_idle();
    for (int n = 1; n <= 10; n++) begin
      n_checks++;
      if (out_valid !== (n == NG)) begin
        n_fail++; $display("FAIL rstmid_stale after %0d edges: out_valid %b want %b",
                           n, out_valid, (n == NG));
      end
      if (n == NG) begin
        n_checks++;
        if ({ovf, cout, sum} !== exp) begin
          n_fail++; $display("FAIL rstmid_result: got %h want %h", {ovf, cout, sum}, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_bubbles();
    bit pat [3] = '{1'b1, 1'b0, 1'b1};
    logic [17:0] exp;
    sb.delete();
    for (int n = 0; n < 10; n++) begin
      if (n < 3) begin
        in_valid = pat[n];
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
      end else begin
        drive_idle();
      end
      tick();
      n_checks++;
      if (out_valid !== (n + 1 == NG || n + 1 == NG + 2)) begin
        n_fail++; $display("FAIL bubble_pattern after %0d edges: out_valid %b", n + 1,
                           out_valid);
      end
      if (out_valid === 1'b1 && sb.size() > 0) begin
        exp = sb.pop_front();
        n_checks++;
        if ({ovf, cout, sum} !== exp) begin
          n_fail++; $display("FAIL bubble_result: got %h want %h", {ovf, cout, sum}, exp);
        end
      end
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL bubble_drain: %0d results missing", sb.size());
    end
  endtask

  task automatic test_random();
    logic [17:0] exp;
    sb.delete();
    drive_idle();
    for (int n = 0; n < 320; n++) begin
      out_ready = (n >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (n >= 300) begin
        drive_idle();
      end else if (!in_valid || last_acc) begin
        in_valid = 1'($urandom_range(0, 1));
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
      end
      #1;
      n_checks++;
      if (out_valid !== mdl_v[NG-1] || in_ready !== !(mdl_v[NG-1] && !out_ready)) begin
        n_fail++; $display("FAIL rand_handshake cyc %0d: out_valid %b in_ready %b want %b %b",
                           n, out_valid, in_ready, mdl_v[NG-1], !(mdl_v[NG-1] && !out_ready));
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rand_extra cyc %0d: result %h with none expected", n,
                             {ovf, cout, sum});
        end else begin
          exp = sb.pop_front();
          if ({ovf, cout, sum} !== exp) begin
            n_fail++; $display("FAIL rand_result cyc %0d: got %h want %h", n,
                               {ovf, cout, sum}, exp);
          end
        end
      end
      tick();
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++; $display("FAIL rand_drain: %0d results missing", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_bubbles();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
